// File: rtl/tpu_pkg.sv
// Shared constants, types and helpers for the TPU core's output-side datapath.
package tpu_pkg;
    localparam int ARRAY_W    = 16;
    localparam int ACCUM_W    = 32;
    localparam int OB_ADDR_W  = 10;
    localparam int BEAT_LANES = 4;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} drain_state_e;

    typedef logic signed [ACCUM_W-1:0] row_t [ARRAY_W];

    function automatic int beats_per_row(input int w, input int l);
        return w / l;
    endfunction
endpackage

// File: rtl/row_fifo.sv
// Two-entry register FIFO holding whole Output Buffer rows between read-back and serialization.
module row_fifo
    import tpu_pkg::*;
#(
    parameter int W  = ARRAY_W,
    parameter int DW = ACCUM_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data [W],
    input  logic          pop,
    output logic [DW-1:0] head [W],
    output logic [1:0]    count,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [2][W];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        for (int i = 0; i < W; i++) begin
            head[i] = mem[rd_ptr][i];
        end
    end

    // Storage is cleared on reset so the head presents zeros while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int e = 0; e < 2; e++) begin
                for (int i = 0; i < W; i++) begin
                    mem[e][i] <= '0;
                end
            end
        end else begin
            if (do_push) begin
                for (int i = 0; i < W; i++) begin
                    mem[wr_ptr][i] <= push_data[i];
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/result_drain.sv
// Drains a contiguous range of Output Buffer rows and streams each row out as
// narrower valid/ready beats toward the host interconnect.
module result_drain
    import tpu_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = ARRAY_W,
    parameter int DATA_WIDTH_ACCUM     = ACCUM_W,
    parameter int ADDR_WIDTH           = OB_ADDR_W,
    parameter int LANES_PER_BEAT       = BEAT_LANES
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [ADDR_WIDTH-1:0]                      base_addr,
    input  logic [ADDR_WIDTH:0]                        num_rows,
    output logic                                       busy,
    output logic                                       done,
    output logic [ADDR_WIDTH-1:0]                      ob_rd_addr,
    output logic                                       ob_rd_en,
    input  logic [DATA_WIDTH_ACCUM-1:0]                ob_rd_data [SYSTOLIC_ARRAY_WIDTH],
    output logic [LANES_PER_BEAT*DATA_WIDTH_ACCUM-1:0] m_data,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic                                       m_last
);
    localparam int W      = SYSTOLIC_ARRAY_WIDTH;
    localparam int DW     = DATA_WIDTH_ACCUM;
    localparam int L      = LANES_PER_BEAT;
    localparam int BEATS  = beats_per_row(W, L);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    if (W % L != 0) begin : g_bad_lanes
        $error("result_drain: SYSTOLIC_ARRAY_WIDTH must be a multiple of LANES_PER_BEAT");
    end

    drain_state_e          state;
    drain_state_e          state_next;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      rows_q;
    logic [CNT_W-1:0]      rows_issued;
    logic [CNT_W-1:0]      rows_sent;
    logic [BEAT_W-1:0]     beat_idx;
    logic                  rd_valid_q;
    logic                  issue;
    logic [1:0]            inflight;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DW-1:0]         head [W];
    logic [L*DW-1:0]       beat_words [BEATS];
    logic                  beat_fire;
    logic                  last_beat;
    logic                  row_pop;

    row_fifo #(.W(W), .DW(DW)) u_row_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_valid_q),
        .push_data (ob_rd_data),
        .pop       (row_pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar j = 0; j < L; j++) begin : g_lane
            assign beat_words[b][j*DW +: DW] = head[b*L + j];
        end
    end

    assign m_valid   = !fifo_empty;
    assign m_data    = m_valid ? beat_words[beat_idx] : '0;
    assign last_beat = (beat_idx == BEAT_W'(BEATS - 1));
    assign beat_fire = m_valid && m_ready;
    assign row_pop   = beat_fire && last_beat;
    assign m_last    = m_valid && last_beat && (rows_sent == rows_q - CNT_W'(1));
    assign inflight  = {1'b0, ob_rd_en} + {1'b0, rd_valid_q};

    // Rows buffered plus rows requested but not yet captured never exceed the two FIFO slots.
    always_comb begin
        issue = 1'b0;
        if (state == IDLE) begin
            issue = start && (num_rows != '0);
        end else if (state == READ) begin
            issue = (rows_issued != rows_q) && !fifo_full &&
                    ((3'(fifo_count) + 3'(inflight)) < 3'd2);
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = (num_rows == '0) ? DONE : READ;
            READ:    if (rows_issued == rows_q) state_next = DRAIN;
            DRAIN:   if (beat_fire && m_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            rows_issued <= '0;
            ob_rd_en    <= 1'b0;
            ob_rd_addr  <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state      <= state_next;
            ob_rd_en   <= issue;
            rd_valid_q <= ob_rd_en;
            if (state == IDLE && start) begin
                base_q      <= base_addr;
                rows_q      <= num_rows;
                rows_issued <= issue ? CNT_W'(1) : '0;
            end else if (issue) begin
                rows_issued <= rows_issued + CNT_W'(1);
            end
            // Address arithmetic truncates, so a range past the top address wraps to zero.
            if (issue) begin
                ob_rd_addr <= (state == IDLE) ? base_addr
                                              : base_q + rows_issued[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx  <= '0;
            rows_sent <= '0;
        end else if (state == IDLE && start) begin
            beat_idx  <= '0;
            rows_sent <= '0;
        end else if (beat_fire) begin
            if (last_beat) begin
                beat_idx  <= '0;
                rows_sent <= rows_sent + CNT_W'(1);
            end else begin
                beat_idx <= beat_idx + BEAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: an Output Buffer model feeds rows, a negedge
// monitor records reads and beats, and the main sequence compares against hand-derived values.
module tb_result_drain;
    import tpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic [10:0]  num_rows;
    logic         busy;
    logic         done;
    logic [9:0]   ob_rd_addr;
    logic         ob_rd_en;
    logic [31:0]  ob_rd_data [16];
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    row_t         ob_mem [1024];
    int           tests = 0;
    int           failed = 0;
    int           cyc = 0;
    bit           rand_ready = 1'b0;

    int           start_cyc = 0;
    int           first_busy_rel = -1;
    int           stab_viol = 0;
    int           max_out = 0;
    int           mon_rel;
    int           mon_out;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    int           rd_addr_q [$];
    int           rd_cyc_q [$];
    logic [127:0] beat_q [$];
    bit           last_q [$];
    int           beat_cyc_q [$];
    int           done_q [$];

    result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .busy       (busy),
        .done       (done),
        .ob_rd_addr (ob_rd_addr),
        .ob_rd_en   (ob_rd_en),
        .ob_rd_data (ob_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output Buffer model: fixed one-cycle read latency.
    always @(posedge clk) begin
        if (ob_rd_en) begin
            for (int i = 0; i < 16; i++) ob_rd_data[i] <= ob_mem[ob_rd_addr][i];
        end
    end

    // Monitor restarts its record whenever a start is accepted in IDLE.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                start_cyc      = cyc;
                first_busy_rel = -1;
                stab_viol      = 0;
                max_out        = 0;
                rd_addr_q.delete();
                rd_cyc_q.delete();
                beat_q.delete();
                last_q.delete();
                beat_cyc_q.delete();
                done_q.delete();
            end
            mon_rel = cyc - start_cyc;
            if (busy && first_busy_rel < 0) first_busy_rel = mon_rel;
            if (ob_rd_en) begin
                rd_addr_q.push_back(int'(ob_rd_addr));
                rd_cyc_q.push_back(mon_rel);
            end
            mon_out = rd_addr_q.size() - beat_q.size() / 4;
            if (mon_out > max_out) max_out = mon_out;
            if (done) done_q.push_back(mon_rel);
            if (prev_stall && m_data !== prev_data) stab_viol++;
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                beat_cyc_q.push_back(mon_rel);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    function automatic logic [127:0] expBeat(input int addr, input int b);
        logic [127:0] v = '0;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = ob_mem[addr][b*4 + j];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    // Holds start for exactly cycle 0; returns 1 ns into cycle 1.
    task automatic applyStimulus(input int base, input int n);
        tick();
        base_addr = 10'(base);
        num_rows  = 11'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        checkOutput({tag, "_done_seen"}, 128'(seen), 128'(1));
        if (seen) begin
            tick();
            @(negedge clk);
            checkOutput({tag, "_busy_after_done"}, 128'(busy), 128'(0));
        end
        tick();
    endtask

    task automatic checkBeats(input string tag, input int base, input int n, input bit gapless);
        checkOutput({tag, "_reads"}, 128'(rd_addr_q.size()), 128'(n));
        checkOutput({tag, "_beats"}, 128'(beat_q.size()), 128'(n * 4));
        for (int r = 0; r < n && r < rd_addr_q.size(); r++)
            checkOutput({tag, "_rd_addr"}, 128'(rd_addr_q[r]), 128'((base + r) % 1024));
        for (int k = 0; k < n * 4 && k < beat_q.size(); k++) begin
            checkOutput({tag, "_data"}, beat_q[k], expBeat((base + k / 4) % 1024, k % 4));
            checkOutput({tag, "_last"}, 128'(last_q[k]), 128'(k == n * 4 - 1));
            if (gapless) checkOutput({tag, "_beat_cycle"}, 128'(beat_cyc_q[k]), 128'(3 + k));
        end
        checkOutput({tag, "_no_stall_change"}, 128'(stab_viol), 128'(0));
        checkOutput({tag, "_credit_bound"}, 128'(max_out <= 2), 128'(1));
    endtask

    initial begin
        bit seen_valid;
        for (int a = 0; a < 1024; a++)
            for (int i = 0; i < 16; i++) ob_mem[a][i] = 32'(a * 256 + i);
        for (int i = 0; i < 16; i++) ob_mem[5][i] = 32'(100 + i);

        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; m_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_busy",     128'(busy),       128'(0));
        checkOutput("rst_done",     128'(done),       128'(0));
        checkOutput("rst_rd_en",    128'(ob_rd_en),   128'(0));
        checkOutput("rst_rd_addr",  128'(ob_rd_addr), 128'(0));
        checkOutput("rst_m_valid",  128'(m_valid),    128'(0));
        checkOutput("rst_m_last",   128'(m_last),     128'(0));
        checkOutput("rst_m_data",   m_data,           128'(0));
        rst = 1'b0;
        tick();

        $display("[TB] single row at address 5");
        applyStimulus(5, 1);
        waitDone("t1", 50);
        checkBeats("t1", 5, 1, 1'b1);
        checkOutput("t1_beat0", beat_q[0], {32'd103, 32'd102, 32'd101, 32'd100});
        checkOutput("t1_beat3", beat_q[3], {32'd115, 32'd114, 32'd113, 32'd112});
        checkOutput("t1_rd_cycle",   128'(rd_cyc_q[0]),    128'(1));
        checkOutput("t1_busy_cycle", 128'(first_busy_rel), 128'(1));
        checkOutput("t1_done_count", 128'(done_q.size()),  128'(1));
        checkOutput("t1_done_cycle", 128'(done_q[0]),      128'(7));

        $display("[TB] eight rows, continuous ready");
        applyStimulus(0, 8);
        waitDone("t2", 100);
        checkBeats("t2", 0, 8, 1'b1);
        checkOutput("t2_done_cycle", 128'(done_q[0]), 128'(35));
        checkOutput("t2_credit_max", 128'(max_out),   128'(2));

        $display("[TB] six rows, random ready");
        rand_ready = 1'b1;
        applyStimulus(100, 6);
        waitDone("t3", 400);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        checkBeats("t3", 100, 6, 1'b0);

        $display("[TB] address wrap");
        applyStimulus(1022, 4);
        waitDone("t4", 100);
        checkBeats("t4", 1022, 4, 1'b1);

        $display("[TB] zero rows");
        applyStimulus(7, 0);
        waitDone("t5", 20);
        checkOutput("t5_done_cycle", 128'(done_q[0]),      128'(1));
        checkOutput("t5_reads",      128'(rd_addr_q.size()), 128'(0));
        checkOutput("t5_beats",      128'(beat_q.size()),  128'(0));
        checkOutput("t5_busy_cycle", 128'(first_busy_rel), 128'(1));

        $display("[TB] start while busy");
        applyStimulus(10, 3);
        repeat (3) tick();
        applyStimulus(500, 1);
        waitDone("t6", 100);
        checkBeats("t6", 10, 3, 1'b1);
        checkOutput("t6_done_count", 128'(done_q.size()), 128'(1));

        $display("[TB] reset during drain");
        applyStimulus(20, 3);
        repeat (8) tick();
        checkOutput("t7_valid_before_rst", 128'(m_valid), 128'(1));
        checkOutput("t7_busy_before_rst",  128'(busy),    128'(1));
        rst = 1'b1;
        #1;
        checkOutput("t7_busy",    128'(busy),       128'(0));
        checkOutput("t7_done",    128'(done),       128'(0));
        checkOutput("t7_rd_en",   128'(ob_rd_en),   128'(0));
        checkOutput("t7_rd_addr", 128'(ob_rd_addr), 128'(0));
        checkOutput("t7_m_valid", 128'(m_valid),    128'(0));
        checkOutput("t7_m_last",  128'(m_last),     128'(0));
        checkOutput("t7_m_data",  m_data,           128'(0));
        tick();
        tick();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen_valid = seen_valid | m_valid | busy | ob_rd_en;
            tick();
        end
        checkOutput("t7_quiet_after_rst", 128'(seen_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
